conv_window_buffer: RTL and testbench

Streaming line-buffer and sliding-window generator sitting directly upstream of the kernel convolution stage. Accepts one signed pixel per valid cycle in raster order and keeps KERNEL_SIZE−1 full image lines plus a KERNEL_SIZE×KERNEL_SIZE register window. Whenever a complete window is available, it presents that window in the exact unpacked 2-D layout the convolution stage's `buffer_in` port expects.

---
 rtl/conv_pkg.sv | 10 +
 rtl/conv_line_delay.sv | 36 +++
 rtl/conv_window_buffer.sv | 106 ++++++++++
 tb/tb_conv_window_buffer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and pixel type for the convolution front end.
package conv_pkg;

  localparam int DEFAULT_KERNEL_SIZE = 3;
  localparam int DEFAULT_WORD_SIZE   = 16;
  localparam int COORD_W             = 16;

  typedef logic signed [DEFAULT_WORD_SIZE-1:0] pixel_t;

endpackage

// File: rtl/conv_line_delay.sv
// One image line of delay: a circular buffer advanced only on enabled cycles.
// The output is the sample written DEPTH enables ago (read-before-write).
module conv_line_delay #(
  parameter int DEPTH     = 640,
  parameter int WORD_SIZE = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic signed [WORD_SIZE-1:0] din,
  output logic signed [WORD_SIZE-1:0] dout
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic signed [WORD_SIZE-1:0] mem [DEPTH];
  logic [PTR_W-1:0]            ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= '0;
    else if (en)
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  end

  // NOTE: the storage array has no reset so it can map onto RAM; stale
  // contents are never exposed because the window is row-gated downstream.
  always_ff @(posedge clk) begin
    if (en)
      mem[ptr] <= din;
  end

endmodule

// File: rtl/conv_window_buffer.sv
// Line buffers plus KxK sliding window feeding the convolution stage.
// Define CONV_WINDOW_COORD_EN to add the win_x/win_y centre-coordinate outputs.
module conv_window_buffer
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = DEFAULT_KERNEL_SIZE,
  parameter int WORD_SIZE   = DEFAULT_WORD_SIZE,
  parameter int IMG_WIDTH   = 640
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sof,
  input  logic                        pixel_valid,
  input  logic signed [WORD_SIZE-1:0] pixel_in,
  output logic signed [WORD_SIZE-1:0] window_out [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0],
  output logic                        window_valid
`ifdef CONV_WINDOW_COORD_EN
  ,
  output logic [COORD_W-1:0]          win_x,
  output logic [COORD_W-1:0]          win_y
`endif
);

  localparam int K     = KERNEL_SIZE;
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int HALF  = (K - 1) / 2;
  localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0]   COL_READY = COL_W'(K - 1);
  localparam logic [COORD_W-1:0] ROW_READY = COORD_W'(K - 1);

  logic [COL_W-1:0]            col, cur_col;
  logic [COORD_W-1:0]          row, cur_row;
  logic                        win_ok;
  logic signed [WORD_SIZE-1:0] lb_in   [K-1];
  logic signed [WORD_SIZE-1:0] lb_out  [K-1];
  logic signed [WORD_SIZE-1:0] new_col [K];

  // Line buffers form a chain: the newest line enters buffer K-2 and each
  // buffer's delayed output feeds the next-older one.
  for (genvar g = 0; g < K - 1; g++) begin : g_line
    if (g == K - 2) begin : g_head
      assign lb_in[g] = pixel_in;
    end else begin : g_link
      assign lb_in[g] = lb_out[g+1];
    end

    conv_line_delay #(
      .DEPTH     (IMG_WIDTH),
      .WORD_SIZE (WORD_SIZE)
    ) u_line (
      .clk   (clk),
      .reset (reset),
      .en    (pixel_valid),
      .din   (lb_in[g]),
      .dout  (lb_out[g])
    );

    assign new_col[g] = lb_out[g];
  end
  assign new_col[K-1] = pixel_in;

  // A pixel flagged sof is coordinate (0,0) regardless of the counters.
  always_comb begin
    cur_col = sof ? '0 : col;
    cur_row = sof ? '0 : row;
    win_ok  = (cur_row >= ROW_READY) && (cur_col >= COL_READY);
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, which the column shift depends on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col          <= '0;
      row          <= '0;
      window_valid <= 1'b0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          window_out[r][c] <= '0;
`ifdef CONV_WINDOW_COORD_EN
      win_x <= '0;
      win_y <= '0;
`endif
    end else begin
      window_valid <= pixel_valid && win_ok;
      if (pixel_valid) begin
        if (cur_col == COL_LAST) begin
          col <= '0;
          row <= (cur_row == '1) ? cur_row : cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++)
            window_out[r][c] <= window_out[r][c+1];
          window_out[r][K-1] <= new_col[r];
        end
`ifdef CONV_WINDOW_COORD_EN
        win_x <= COORD_W'(cur_col) - COORD_W'(HALF);
        win_y <= cur_row - COORD_W'(HALF);
`endif
      end
    end
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer with K=3, 8-bit pixels, 4-pixel lines.
module tb_conv_window_buffer;

  localparam int K  = 3;
  localparam int WS = 8;
  localparam int IW = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 sof;
  logic                 pixel_valid;
  logic signed [WS-1:0] pixel_in;
  logic signed [WS-1:0] window_out [K-1:0][K-1:0];
  logic                 window_valid;

  int n_total = 0;
  int n_pass  = 0;

  conv_window_buffer #(
    .KERNEL_SIZE (K),
    .WORD_SIZE   (WS),
    .IMG_WIDTH   (IW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sof          (sof),
    .pixel_valid  (pixel_valid),
    .pixel_in     (pixel_in),
    .window_out   (window_out),
    .window_valid (window_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_total++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [71:0] dut_window();
    logic [71:0] v = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        v[(r*K+c)*WS +: WS] = window_out[r][c];
    return v;
  endfunction

  function automatic int pix_val(input int row, input int col, input bit neg);
    return neg ? -(10*row + col) : (10*row + col);
  endfunction

  // Window whose newest pixel is (row,col): element [r][c] is pixel (row-2+r, col-2+c).
  function automatic logic [71:0] exp_window(input int row, input int col, input bit neg);
    logic [71:0] v = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        v[(r*K+c)*WS +: WS] = WS'(pix_val(row - (K-1) + r, col - (K-1) + c, neg));
    return v;
  endfunction

  task automatic idle_cycle(input string tag);
    pixel_valid = 1'b0;
    sof         = 1'b0;
    @(posedge clk); #1;
    check({tag, "_gap_valid"}, 72'(window_valid), 72'(0));
  endtask

  // Streams npix pixels in raster order from (0,0), optionally with sof on the
  // first pixel, random idle gaps and negated data; checks every strobe.
  task automatic run_pixels(input string tag, input int npix, input bit first_sof,
                            input bit neg, input bit gaps);
    for (int i = 0; i < npix; i++) begin
      int row = i / IW;
      int col = i % IW;
      bit exp_v = (row >= K-1) && (col >= K-1);
      if (gaps && ($urandom_range(0, 1) == 1))
        idle_cycle(tag);
      pixel_valid = 1'b1;
      sof         = first_sof && (i == 0);
      pixel_in    = WS'(pix_val(row, col, neg));
      @(posedge clk); #1;
      pixel_valid = 1'b0;
      sof         = 1'b0;
      check($sformatf("%s_valid_r%0d_c%0d", tag, row, col), 72'(window_valid), 72'(exp_v));
      if (exp_v)
        check($sformatf("%s_win_r%0d_c%0d", tag, row, col), dut_window(), exp_window(row, col, neg));
    end
  endtask

  initial begin
    reset       = 1'b1;
    sof         = 1'b0;
    pixel_valid = 1'b0;
    pixel_in    = '0;
    #12;
    check("reset_valid", 72'(window_valid), 72'(0));
    check("reset_window", dut_window(), 72'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Continuous 4-line frame: covers first strobe, next strobe and line wrap.
    run_pixels("cont", 16, 1'b1, 1'b0, 1'b0);
    idle_cycle("cont");

    // Same frame with random idle cycles.
    run_pixels("gaps", 16, 1'b1, 1'b0, 1'b1);

    // Negative pixel values.
    run_pixels("neg", 12, 1'b1, 1'b1, 1'b0);

    // Abandon a frame at (2,0); the sof pixel restarts it at (0,0).
    run_pixels("pre_sof", 9, 1'b1, 1'b0, 1'b0);
    run_pixels("restart", 12, 1'b1, 1'b0, 1'b0);

    // Async reset right after a strobe, then a frame with no sof.
    run_pixels("pre_rst", 11, 1'b1, 1'b0, 1'b0);
    check("pre_rst_strobe", 72'(window_valid), 72'(1));
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 72'(window_valid), 72'(0));
    check("async_rst_window", dut_window(), 72'(0));
    #3 reset = 1'b0;
    @(posedge clk); #1;
    run_pixels("post_rst", 16, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
